// File: rtl/parallel_bitgen7.sv
// Parallel stochastic bitstream generator: emits 7-lane words whose popcount
// averages a programmed 3.FRAC density, with lanes filled by cyclic rotation.
module parallel_bitgen7 #(
  parameter int unsigned FRAC = 4,
  parameter int unsigned LENW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC+2:0]   in_val,
  input  logic [LENW-1:0]   in_len,
  output logic [6:0]        out,
  output logic              out_valid,
  output logic              done
);

  localparam int unsigned VW = FRAC + 3;
  localparam logic [VW-1:0] VAL_MAX = VW'(7 << FRAC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [VW-1:0]   val_q, val_d;
  logic [FRAC-1:0] acc_q, acc_d;
  logic [2:0]      rot_q, rot_d;
  logic [LENW-1:0] rem_q, rem_d;

  logic            accept_c;
  logic [VW-1:0]   val_sat_c;
  logic [FRAC:0]   sum_c;
  logic [3:0]      k_c;
  logic [6:0]      therm_c;
  logic [6:0]      word_c;
  logic [3:0]      rot_sum_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_c) state_d = (in_len == '0) ? S_DONE : S_RUN;
      S_RUN:  if (rem_q == LENW'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; out is gated so it reads zero outside a burst word
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    out       = '0;
    case (state_q)
      S_IDLE: in_ready = ~rst;
      S_RUN: begin
        out_valid = 1'b1;
        out       = word_c;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign accept_c  = in_valid & in_ready;
  assign val_sat_c = (in_val > VAL_MAX) ? VAL_MAX : in_val;

  // Per-word ones count: integer part plus carry out of the fraction accumulator
  always_comb begin
    sum_c     = {1'b0, acc_q} + {1'b0, val_q[FRAC-1:0]};
    k_c       = {1'b0, val_q[FRAC+2:FRAC]} + 4'(sum_c[FRAC]);
    therm_c   = 7'((8'd1 << k_c) - 8'd1);
    rot_sum_c = {1'b0, rot_q} + k_c;
  end

  // Rotate the thermometer code left by rot within 7 lanes
  always_comb begin
    word_c = therm_c;
    case (rot_q)
      3'd0: word_c = therm_c;
      3'd1: word_c = {therm_c[5:0], therm_c[6]};
      3'd2: word_c = {therm_c[4:0], therm_c[6:5]};
      3'd3: word_c = {therm_c[3:0], therm_c[6:4]};
      3'd4: word_c = {therm_c[2:0], therm_c[6:3]};
      3'd5: word_c = {therm_c[1:0], therm_c[6:2]};
      3'd6: word_c = {therm_c[0],   therm_c[6:1]};
      default: word_c = therm_c;
    endcase
  end

  // Datapath next-state: load on accept, advance only while running
  always_comb begin
    val_d = val_q;
    acc_d = acc_q;
    rot_d = rot_q;
    rem_d = rem_q;
    if (state_q == S_IDLE && accept_c) begin
      val_d = val_sat_c;
      acc_d = '0;
      rot_d = '0;
      rem_d = in_len;
    end else if (state_q == S_RUN) begin
      acc_d = sum_c[FRAC-1:0];
      rot_d = (rot_sum_c >= 4'd7) ? 3'(rot_sum_c - 4'd7) : 3'(rot_sum_c);
      rem_d = rem_q - LENW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      acc_q <= '0;
      rot_q <= '0;
      rem_q <= '0;
    end else begin
      val_q <= val_d;
      acc_q <= acc_d;
      rot_q <= rot_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: tb/tb_parallel_bitgen7.sv
// Scoreboard bench for parallel_bitgen7: an independent floor-based model
// predicts each burst word; a monitor pops and compares as words appear.
module tb_parallel_bitgen7;
  localparam int unsigned FRAC = 4;
  localparam int unsigned LENW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, in_ready, out_valid, done;
  logic [FRAC+2:0]   in_val;
  logic [LENW-1:0]   in_len;
  logic [6:0]        out;

  int total = 0;
  int bad   = 0;
  int ones  = 0;

  typedef struct {
    bit         is_done;
    logic [6:0] w;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  parallel_bitgen7 #(.FRAC(FRAC), .LENW(LENW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_val(in_val), .in_len(in_len), .out(out), .out_valid(out_valid),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word n of a burst: ones so far = floor(n*v/16); lanes start where previous ones stopped
  function automatic logic [6:0] model_word(input int v, input int n);
    int a, b, k, r, t;
    a = (n * v) / (1 << FRAC);
    b = ((n + 1) * v) / (1 << FRAC);
    k = b - a;
    r = a % 7;
    t = (1 << k) - 1;
    return 7'(((t << r) | (t >> (7 - r))) & 127);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid || done) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'({out_valid, done}), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("kind", 32'({out_valid, done}), e.is_done ? 32'd1 : 32'd2);
          chk("word", 32'(out), 32'(e.w));
        end
        if (out_valid) ones += $countones(out);
      end else begin
        chk("idle_out", 32'(out), 32'd0);
      end
    end
  end

  // Wait for ready, push predictions, accept at the next edge; returns in cycle T+1
  task automatic start_burst(input int v, input int l, input bit hold);
    int vs;
    int n;
    exp_t x;
    in_val   = (FRAC+3)'(v);
    in_len   = LENW'(l);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    vs = (v > 7 * (1 << FRAC)) ? 7 * (1 << FRAC) : v;
    for (int i = 0; i < l; i++) begin
      x.is_done = 1'b0;
      x.w = model_word(vs, i);
      sb.push_back(x);
    end
    x.is_done = 1'b1;
    x.w = 7'd0;
    sb.push_back(x);
    @(posedge clk); #1;
    if (hold) begin
      in_val = (FRAC+3)'($urandom);
      in_len = LENW'($urandom_range(1, 255));
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic check_timeline(input int l);
    for (int c = 1; c <= l + 2; c++) begin
      if (c == l + 1) in_valid = 1'b0;
      @(negedge clk);
      chk("tl_valid", 32'(out_valid), 32'(c <= l));
      chk("tl_done", 32'(done), 32'(c == l + 1));
      chk("tl_ready", 32'(in_ready), 32'(c == l + 2));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_val = '0; in_len = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    start_burst(48, 4, 1'b0);
    check_timeline(4);

    ones = 0;
    start_burst(40, 4, 1'b0);
    check_timeline(4);
    chk("ones_2p5", 32'(ones), 32'd10);

    start_burst(127, 3, 1'b0);
    check_timeline(3);

    start_burst(50, 0, 1'b0);
    check_timeline(0);

    // Reset during the third word aborts the burst silently
    start_burst(60, 5, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    start_burst(16, 2, 1'b0);
    check_timeline(2);

    ones = 0;
    start_burst(1, 32, 1'b1);
    check_timeline(32);
    chk("ones_1_16", 32'(ones), 32'd2);

    for (int i = 0; i < 8; i++) begin
      int v, l;
      v = $urandom_range(0, 127);
      l = $urandom_range(0, 9);
      start_burst(v, l, 1'b0);
      check_timeline(l);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parallel_bitgen7.md
# parallel_bitgen7

Parallel stochastic bitstream generator that drives 7 lanes with a programmed density of ones. It accepts a fixed-point value in units of ones-per-cycle (0.0 to 7.0) and a burst length. For that many cycles it emits a 7-bit word whose popcount averages the value. It is the source-side counterpart of the 7-input parallel counter (popcount) in the stochastic compute unit, and feeds parallel-lane SC datapaths whose outputs are later summed by that counter.

## Interface
- FRAC, 4, fractional bits of the density value
- LENW, 8, width of the burst-length field
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request to load a new burst
- in_ready  output  1  block can accept a burst; high only in IDLE and while rst=0
- in_val  input  3+FRAC  density, unsigned fixed point 3.FRAC (ones per cycle)
- in_len  input  LENW  number of output words in the burst
- out  output  7  generated lane word; 0 when out_valid=0
- out_valid  output  1  out carries a burst word this cycle
- done  output  1  one-cycle pulse when a burst completes

## Operation
- States: IDLE, RUN, DONE.
- Registers: val (3.FRAC), acc (FRAC bits), rot (0..6), rem (LENW bits).
- IDLE, in_valid & in_ready at an edge:
  - val <= min(in_val, 7<<FRAC), so values above 7.0 saturate to exactly 7.0.
  - acc <= 0, rot <= 0, rem <= in_len.
  - Next state is DONE if in_len==0, else RUN.
- RUN, combinational per cycle:
  - sum = acc + val[FRAC-1:0], carry = sum[FRAC].
  - k = val[FRAC+2:FRAC] + carry. k<=7 is guaranteed by saturation.
  - therm = k ones in bits [k-1:0].
  - out[(i+rot)%7] = therm[i], i.e. rotate left by rot within 7 bits.
  - out_valid = 1.
- RUN, at each edge:
  - acc <= sum[FRAC-1:0].
  - rot <= (rot+k) mod 7.
  - rem <= rem-1.
  - If rem==1, the next state is DONE.
- DONE: done=1, out_valid=0, in_ready=0; next state IDLE.
- in_valid is ignored outside IDLE. The loaded burst parameters are never disturbed mid-burst.
- Exactness: total ones over a burst = floor(in_len*val_sat / 2^FRAC). Per-word k is floor or ceil of val_sat.
- Lane fairness: rotation advances by k each word, so consecutive words fill lanes cyclically. Over any 7 consecutive words with constant k, each lane receives exactly k ones.

## Timing
- Burst accepted at edge T:
  - words valid in cycles T+1 .. T+in_len;
  - done high in cycle T+in_len+1;
  - in_ready high again from cycle T+in_len+2.
- in_len==0: no out_valid; done high in cycle T+1.
- Back-to-back bursts: minimum spacing is in_len+2 cycles between acceptances.
- Reset (rst=1 at an edge): state IDLE, acc=0, rot=0, rem=0, out=0, out_valid=0, done=0.
  - in_ready is 0 while rst=1 and 1 the first cycle after rst drops.
  - Reset mid-RUN or in DONE aborts the burst with no done pulse.
  - The next burst restarts with acc=0, rot=0.
- No combinational path from in_valid to out.
- in_ready depends only on state and rst.

## Test plan
- FRAC=4, in_val=48 (3.0), in_len=4:
  - out = 7'b0000111, 7'b0111000, 7'b1000011, 7'b0011100 in cycles T+1..T+4;
  - done at T+5.
- in_val=40 (2.5), in_len=4:
  - k sequence 2,3,2,3;
  - total ones 10;
  - rot sequence 0,2,5,0.
- in_val=127 (7.9375, saturated to 7.0), in_len=3: out=7'h7F for three words, then done.
- in_len=0: out_valid stays 0, done pulses in cycle T+1, in_ready returns at T+2.
- rst pulsed during the 3rd word of a 5-word burst:
  - next cycle out_valid=0, done=0, in_ready=1;
  - new burst in_val=16, in_len=2 gives 7'b0000001, 7'b0000010.
- in_val=1 (1/16), in_len=32, in_valid held high throughout:
  - exactly 2 ones total, on words 16 and 32;
  - no reload before done.
